// File: rtl/uart_type_split.sv
// Transmit-side framer for the typed UART link.
// Wraps a payload stream as HEAD0, HEAD1, TYPE, LEN, payload, CSUM and hands
// bytes to the UART TX core through a registered valid/ready output stage.
module uart_type_split #(
  parameter logic [7:0] HEAD0 = 8'h55,
  parameter logic [7:0] HEAD1 = 8'hAA
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start_valid,
  output logic       o_start_ready,
  input  logic [7:0] i_type,
  input  logic [7:0] i_len,
  input  logic [7:0] i_data,
  input  logic       i_data_valid,
  output logic       o_data_ready,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic       o_busy,
  output logic       o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD0,
    S_HEAD1,
    S_TYPE,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_WAIT_LAST
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [7:0] type_q;
  logic [7:0] len_q;
  logic [7:0] csum_q;
  logic [7:0] cnt_q;

  logic       load_ok;
  logic       start_hs;
  logic       pay_hs;
  logic       last_hs;
  logic       load_en;
  logic [7:0] load_byte;
  logic       csum_add;

  // State register with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: each header/CSUM state advances once its byte is loaded
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:      if (start_hs) state_nxt = S_HEAD0;
      S_HEAD0:     if (load_ok)  state_nxt = S_HEAD1;
      S_HEAD1:     if (load_ok)  state_nxt = S_TYPE;
      S_TYPE:      if (load_ok)  state_nxt = S_LEN;
      S_LEN:       if (load_ok)  state_nxt = (len_q == 8'd0) ? S_CSUM : S_PAYLOAD;
      // counter holds bytes still to send, so 1 here means this is the last one
      S_PAYLOAD:   if (pay_hs && (cnt_q == 8'd1)) state_nxt = S_CSUM;
      S_CSUM:      if (load_ok)  state_nxt = S_WAIT_LAST;
      S_WAIT_LAST: if (last_hs)  state_nxt = S_IDLE;
      default:                   state_nxt = S_IDLE;
    endcase
  end

  // Output/control decode: handshakes, which byte to load, checksum enable
  always_comb begin
    load_ok       = !o_tx_valid || i_tx_ready;
    o_start_ready = (state == S_IDLE) && i_rst;
    o_data_ready  = (state == S_PAYLOAD) && load_ok;
    start_hs      = i_start_valid && o_start_ready;
    pay_hs        = o_data_ready && i_data_valid;
    last_hs       = (state == S_WAIT_LAST) && o_tx_valid && i_tx_ready;
    load_en       = 1'b0;
    load_byte     = '0;
    csum_add      = 1'b0;
    unique case (state)
      S_HEAD0: begin
        load_en   = load_ok;
        load_byte = HEAD0;
      end
      S_HEAD1: begin
        load_en   = load_ok;
        load_byte = HEAD1;
      end
      S_TYPE: begin
        load_en   = load_ok;
        load_byte = type_q;
        csum_add  = load_ok;
      end
      S_LEN: begin
        load_en   = load_ok;
        load_byte = len_q;
        csum_add  = load_ok;
      end
      S_PAYLOAD: begin
        load_en   = pay_hs;
        load_byte = i_data;
        csum_add  = pay_hs;
      end
      S_CSUM: begin
        load_en   = load_ok;
        load_byte = csum_q;
      end
      default: ;
    endcase
  end

  // Datapath: request latch, checksum/counter, output register, busy/done
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      type_q     <= '0;
      len_q      <= '0;
      csum_q     <= '0;
      cnt_q      <= '0;
      o_tx_data  <= '0;
      o_tx_valid <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      if (start_hs) begin
        type_q <= i_type;
        len_q  <= i_len;
        csum_q <= '0;
        cnt_q  <= i_len;
        o_busy <= 1'b1;
      end
      if (csum_add) csum_q <= csum_q + load_byte;
      if (pay_hs)   cnt_q  <= cnt_q - 8'd1;
      if (load_en) begin
        o_tx_data  <= load_byte;
        o_tx_valid <= 1'b1;
      end else if (i_tx_ready) begin
        o_tx_valid <= 1'b0;
      end
      o_done <= last_hs;
      if (last_hs) o_busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_type_split.sv
// Bench for uart_type_split: randomized frames against a frame-level model.
module tb_uart_type_split;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_start_valid = 1'b0;
  logic       o_start_ready;
  logic [7:0] i_type = '0;
  logic [7:0] i_len = '0;
  logic [7:0] i_data = '0;
  logic       i_data_valid = 1'b0;
  logic       o_data_ready;
  logic [7:0] o_tx_data;
  logic       o_tx_valid;
  logic       i_tx_ready = 1'b1;
  logic       o_busy;
  logic       o_done;

  int n_checks = 0;
  int n_errors = 0;

  bit         bp_mode = 1'b0;
  logic [7:0] pay_q[$];
  logic [7:0] obs_q[$];
  int         done_cnt = 0;
  int         dready_cnt = 0;

  uart_type_split #(.HEAD0(8'h55), .HEAD1(8'hAA)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start_valid (i_start_valid),
    .o_start_ready (o_start_ready),
    .i_type        (i_type),
    .i_len         (i_len),
    .i_data        (i_data),
    .i_data_valid  (i_data_valid),
    .o_data_ready  (o_data_ready),
    .o_tx_data     (o_tx_data),
    .o_tx_valid    (o_tx_valid),
    .i_tx_ready    (i_tx_ready),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  always #5 i_clk = ~i_clk;

  // Downstream ready: constant 1 or random backpressure
  always @(posedge i_clk) begin
    #1;
    i_tx_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: collect accepted bytes, done pulses and payload-ready cycles
  always @(negedge i_clk) begin
    if (i_rst) begin
      if (o_tx_valid && i_tx_ready) obs_q.push_back(o_tx_data);
      if (o_done) done_cnt++;
      if (o_data_ready) dready_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_req(input logic [7:0] ftype, input logic [7:0] flen, output bit acc);
    acc = 1'b0;
    i_start_valid = 1'b1;
    i_type = ftype;
    i_len  = flen;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge i_clk);
      acc = o_start_ready;
      @(posedge i_clk);
      #1;
    end
    i_start_valid = 1'b0;
    if (!acc) check("start_timeout", 32'd0, 32'd1);
  endtask

  // Send one frame from pay_q and compare against the expected wire image
  task automatic run_frame(input logic [7:0] ftype, input logic [7:0] flen,
                           input int gap, input bit bp, input bit check_lat);
    logic [7:0] exp_q[$];
    logic [7:0] sum;
    bit         acc;
    int         idx, gcnt, cyc;
    exp_q = {8'h55, 8'hAA, ftype, flen};
    sum = ftype + flen;
    foreach (pay_q[i]) begin
      exp_q.push_back(pay_q[i]);
      sum = sum + pay_q[i];
    end
    exp_q.push_back(sum);

    bp_mode = bp;
    obs_q.delete();
    done_cnt = 0;
    dready_cnt = 0;
    start_req(ftype, flen, acc);
    if (check_lat) begin
      @(negedge i_clk);
      check("lat_cycle1_valid", 32'(o_tx_valid), 32'd0);
      check("lat_cycle1_busy", 32'(o_busy), 32'd1);
      @(posedge i_clk); #1;
      @(negedge i_clk);
      check("lat_cycle2_valid", 32'(o_tx_valid), 32'd1);
      check("lat_cycle2_head0", 32'(o_tx_data), 32'h55);
      @(posedge i_clk); #1;
    end

    idx = 0; gcnt = 0; cyc = 0;
    while (!(done_cnt > 0 && idx >= int'(flen)) && cyc < 6000) begin
      i_data_valid = (idx < int'(flen)) && (gcnt == 0);
      i_data = i_data_valid ? pay_q[idx] : 8'($urandom);
      @(negedge i_clk);
      if (i_data_valid && o_data_ready) begin
        idx++;
        gcnt = gap;
      end else if (!i_data_valid && gcnt > 0) begin
        gcnt--;
      end
      @(posedge i_clk); #1;
      cyc++;
    end
    i_data_valid = 1'b0;
    if (cyc >= 6000) check("frame_timeout", 32'(cyc), 32'd0);
    repeat (2) begin
      @(posedge i_clk); #1;
    end
    bp_mode = 1'b0;

    check("done_once", 32'(done_cnt), 32'd1);
    check("busy_after", 32'(o_busy), 32'd0);
    check("byte_count", 32'(obs_q.size()), 32'(exp_q.size()));
    if (flen == 8'd0) check("dready_len0", 32'(dready_cnt), 32'd0);
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("byte%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    bit acc;
    int rl;

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_valid", 32'(o_tx_valid), 32'd0);
    check("rst_data", 32'(o_tx_data), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_dready", 32'(o_data_ready), 32'd0);
    check("rst_sready_low", 32'(o_start_ready), 32'd0);
    i_rst = 1'b1;
    #1;
    check("rst_sready_rel", 32'(o_start_ready), 32'd1);
    @(posedge i_clk); #1;

    // Basic frame with latency check
    pay_q = {8'h10, 8'h20};
    run_frame(8'h03, 8'd2, 0, 1'b0, 1'b1);

    // Zero length
    pay_q.delete();
    run_frame(8'h7F, 8'd0, 0, 1'b0, 1'b1);

    // Backpressure on the basic frame
    pay_q = {8'h10, 8'h20};
    run_frame(8'h03, 8'd2, 0, 1'b1, 1'b0);

    // Payload bubbles and checksum wrap
    pay_q = {8'hFF, 8'hFF, 8'h02};
    run_frame(8'hFF, 8'd3, 2, 1'b0, 1'b0);

    // Maximum length
    pay_q.delete();
    for (int i = 0; i < 255; i++) pay_q.push_back(8'(i));
    run_frame(8'h5A, 8'd255, 0, 1'b0, 1'b0);

    // Reset during the first payload byte of a 4-byte frame
    bp_mode = 1'b0;
    obs_q.delete();
    start_req(8'h11, 8'd4, acc);
    i_data = 8'hC3;
    i_data_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge i_clk);
      if (o_data_ready) begin
        @(posedge i_clk); #1;
        break;
      end
      @(posedge i_clk); #1;
    end
    i_data_valid = 1'b0;
    check("pre_reset_busy", 32'(o_busy), 32'd1);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    check("mid_rst_valid", 32'(o_tx_valid), 32'd0);
    check("mid_rst_busy", 32'(o_busy), 32'd0);
    check("mid_rst_done", 32'(o_done), 32'd0);
    i_rst = 1'b1;
    #1;
    check("mid_rst_sready", 32'(o_start_ready), 32'd1);
    @(posedge i_clk); #1;
    pay_q = {8'h01, 8'h02, 8'h03, 8'h04};
    run_frame(8'h11, 8'd4, 0, 1'b0, 1'b0);

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      rl = $urandom_range(0, 20);
      pay_q.delete();
      for (int i = 0; i < rl; i++) pay_q.push_back(8'($urandom));
      run_frame(8'($urandom), 8'(rl), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
